// File: rtl/dll_pkg.sv
// Shared types for the DLL lock controller: loop states, step direction and counter sizing.
package dll_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StTrack   = 2'd2,
        StManual  = 2'd3
    } dll_state_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dll_dir_e;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dll_updn_filter.sv
// Signed early/late accumulator; emits a single-cycle step when the running sum hits +/-thresh.
module dll_updn_filter #(
    parameter int unsigned ACC_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    valid,
    input  logic                    late,
    input  logic signed [ACC_W-1:0] thresh,
    output logic                    step_up,
    output logic                    step_dn
);

    localparam logic signed [ACC_W-1:0] ONE = ACC_W'(1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;

    always_comb begin
        acc_nxt = late ? (acc - ONE) : (acc + ONE);
        step_up = valid && (acc_nxt >= thresh);
        step_dn = valid && (acc_nxt <= -thresh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (valid) begin
            acc <= (step_up || step_dn) ? '0 : acc_nxt;
        end
    end

endmodule

// File: rtl/dll_lock_ctrl.sv
// DLL loop controller: filters phase-detector samples, steps a saturating delay code, tracks lock.
module dll_lock_ctrl
    import dll_pkg::*;
#(
    parameter int unsigned CODE_W    = 6,
    parameter int unsigned CODE_INIT = 32,
    parameter int unsigned FILT_TH   = 4,
    parameter int unsigned LOCK_REV  = 4,
    parameter int unsigned LOSS_RUN  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pd_valid,
    input  logic              pd_late,
    input  logic              freeze,
    input  logic              manual_en,
    input  logic [CODE_W-1:0] manual_code,
    output logic [CODE_W-1:0] code_o,
    output logic              locked_o,
    output logic              sat_o,
    output logic [1:0]        state_o
);

    localparam int unsigned ACC_W = $clog2(FILT_TH) + 2;
    localparam int unsigned REV_W = cnt_w(LOCK_REV);
    localparam int unsigned RUN_W = cnt_w(LOSS_RUN);

    localparam logic [CODE_W-1:0]       CODE_RST = CODE_W'(CODE_INIT);
    localparam logic [CODE_W-1:0]       CODE_MAX = {CODE_W{1'b1}};
    localparam logic signed [ACC_W-1:0] TH_ACQ   = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] TH_TRK   = ACC_W'(FILT_TH);
    localparam logic [REV_W-1:0]        REV_LIM  = REV_W'(LOCK_REV);
    localparam logic [RUN_W-1:0]        RUN_LIM  = RUN_W'(LOSS_RUN);

    dll_state_e        state;
    logic [CODE_W-1:0] code;
    logic              locked;
    logic              sat;
    logic [REV_W-1:0]  rev_cnt;
    logic [RUN_W-1:0]  run_cnt;
    logic              has_prev;
    dll_dir_e          prev_dir;

    logic                    loop_act;
    logic                    filt_clr;
    logic                    filt_valid;
    logic signed [ACC_W-1:0] thresh;
    logic                    step_up;
    logic                    step_dn;
    logic                    step_any;
    dll_dir_e                step_dir;
    logic                    same_dir;
    logic                    reversal;
    logic [REV_W-1:0]        rev_nxt;
    logic [RUN_W-1:0]        run_nxt;

    always_comb begin
        loop_act   = (state == StAcquire) || (state == StTrack);
        filt_clr   = !en || manual_en || !loop_act;
        filt_valid = pd_valid && !freeze && en && !manual_en && loop_act;
        thresh     = (state == StTrack) ? TH_TRK : TH_ACQ;
    end

    dll_updn_filter #(
        .ACC_W (ACC_W)
    ) u_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (filt_clr),
        .valid   (filt_valid),
        .late    (pd_late),
        .thresh  (thresh),
        .step_up (step_up),
        .step_dn (step_dn)
    );

    // Counters saturate so they cannot wrap in the state where they are not being watched.
    always_comb begin
        step_any = step_up || step_dn;
        step_dir = step_dn ? DIR_DN : DIR_UP;
        same_dir = has_prev && (prev_dir == step_dir);
        reversal = has_prev && (prev_dir != step_dir);
        rev_nxt  = '0;
        run_nxt  = RUN_W'(1);
        if (reversal) begin
            rev_nxt = (rev_cnt == REV_LIM) ? rev_cnt : rev_cnt + REV_W'(1);
        end
        if (same_dir) begin
            run_nxt = (run_cnt == RUN_LIM) ? run_cnt : run_cnt + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            code     <= CODE_RST;
            locked   <= 1'b0;
            sat      <= 1'b0;
            rev_cnt  <= '0;
            run_cnt  <= '0;
            has_prev <= 1'b0;
            prev_dir <= DIR_UP;
        end else begin
            sat <= 1'b0;
            if (!en) begin
                state    <= StIdle;
                code     <= CODE_RST;
                locked   <= 1'b0;
                rev_cnt  <= '0;
                run_cnt  <= '0;
                has_prev <= 1'b0;
            end else if (manual_en) begin
                state    <= StManual;
                code     <= manual_code;
                locked   <= 1'b0;
                rev_cnt  <= '0;
                run_cnt  <= '0;
                has_prev <= 1'b0;
            end else if (!freeze) begin
                unique case (state)
                    StIdle, StManual: begin
                        if (state == StIdle) begin
                            code <= CODE_RST;
                        end
                        state    <= StAcquire;
                        rev_cnt  <= '0;
                        run_cnt  <= '0;
                        has_prev <= 1'b0;
                    end
                    StAcquire, StTrack: begin
                        if (step_any) begin
                            if (step_up && (code == CODE_MAX)) begin
                                sat <= 1'b1;
                            end else if (step_dn && (code == '0)) begin
                                sat <= 1'b1;
                            end else if (step_up) begin
                                code <= code + CODE_W'(1);
                            end else begin
                                code <= code - CODE_W'(1);
                            end
                            if ((state == StAcquire) && (rev_nxt == REV_LIM)) begin
                                state    <= StTrack;
                                locked   <= 1'b1;
                                rev_cnt  <= '0;
                                run_cnt  <= '0;
                                has_prev <= 1'b1;
                                prev_dir <= step_dir;
                            end else if ((state == StTrack) && (run_nxt == RUN_LIM)) begin
                                state    <= StAcquire;
                                locked   <= 1'b0;
                                rev_cnt  <= '0;
                                run_cnt  <= '0;
                                has_prev <= 1'b0;
                            end else begin
                                rev_cnt  <= rev_nxt;
                                run_cnt  <= run_nxt;
                                has_prev <= 1'b1;
                                prev_dir <= step_dir;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign code_o   = code;
    assign locked_o = locked;
    assign sat_o    = sat;
    assign state_o  = state;

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Directed bench for dll_lock_ctrl: behavioural reference model feeds a per-cycle scoreboard.
module tb_dll_lock_ctrl;

    typedef struct {
        logic [5:0] code;
        logic       locked;
        logic       sat;
        logic [1:0] state;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       pd_valid;
    logic       pd_late;
    logic       freeze;
    logic       manual_en;
    logic [5:0] manual_code;
    logic [5:0] code_o;
    logic       locked_o;
    logic       sat_o;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_errors = 0;
    int sat_seen;
    exp_t exp_q[$];

    // Reference model state, plain integers.
    int m_state, m_code, m_locked, m_sat, m_acc, m_rev, m_run, m_prev;

    dll_lock_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pd_valid    (pd_valid),
        .pd_late     (pd_late),
        .freeze      (freeze),
        .manual_en   (manual_en),
        .manual_code (manual_code),
        .code_o      (code_o),
        .locked_o    (locked_o),
        .sat_o       (sat_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_code = 32; m_locked = 0; m_sat = 0;
        m_acc = 0; m_rev = 0; m_run = 0; m_prev = 0;
    endtask

    task automatic model(input bit e, input bit man, input int mc, input bit frz,
                         input bit v, input bit l);
        int th, dir, nc;
        m_sat = 0;
        if (!e) begin
            m_state = 0; m_code = 32; m_locked = 0;
            m_acc = 0; m_rev = 0; m_run = 0; m_prev = 0;
        end else if (man) begin
            m_state = 3; m_code = mc; m_locked = 0;
            m_acc = 0; m_rev = 0; m_run = 0; m_prev = 0;
        end else if (frz) begin
            // everything held
        end else if (m_state == 0 || m_state == 3) begin
            if (m_state == 0) m_code = 32;
            m_state = 1; m_acc = 0; m_rev = 0; m_run = 0; m_prev = 0;
        end else if (v) begin
            th = (m_state == 2) ? 4 : 1;
            m_acc += l ? -1 : 1;
            dir = 0;
            if (m_acc >= th) dir = 1;
            else if (m_acc <= -th) dir = -1;
            if (dir != 0) begin
                m_acc = 0;
                nc = m_code + dir;
                if (nc < 0 || nc > 63) m_sat = 1;
                else m_code = nc;
                if (m_prev == 0) begin
                    m_rev = 0; m_run = 1;
                end else if (m_prev == dir) begin
                    m_rev = 0; m_run++;
                end else begin
                    m_rev++; m_run = 1;
                end
                m_prev = dir;
                if (m_state == 1 && m_rev >= 4) begin
                    m_state = 2; m_locked = 1; m_rev = 0; m_run = 0;
                end else if (m_state == 2 && m_run >= 8) begin
                    m_state = 1; m_locked = 0; m_rev = 0; m_run = 0; m_prev = 0;
                end
            end
        end
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare after the edge.
    task automatic step(input bit e, input bit man, input int mc, input bit frz,
                        input bit v, input bit l);
        exp_t x;
        en = e; manual_en = man; manual_code = 6'(mc); freeze = frz;
        pd_valid = v; pd_late = l;
        model(e, man, mc, frz, v, l);
        x.code = 6'(m_code); x.locked = m_locked[0]; x.sat = m_sat[0]; x.state = 2'(m_state);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        chk("code", 32'(code_o), 32'(x.code));
        chk("locked", 32'(locked_o), 32'(x.locked));
        chk("sat", 32'(sat_o), 32'(x.sat));
        chk("state", 32'(state_o), 32'(x.state));
        sat_seen += int'(sat_o);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; pd_valid = 1'b1; pd_late = 1'b0;
        freeze = 1'b0; manual_en = 1'b0; manual_code = '0;
        sat_seen = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_code", 32'(code_o), 32);
        chk("rst_locked", 32'(locked_o), 0);
        chk("rst_sat", 32'(sat_o), 0);
        chk("rst_state", 32'(state_o), 0);
        rst_n = 1'b1;

        // IDLE -> ACQUIRE, then one code step per early sample
        step(1, 0, 0, 0, 1, 0);
        chk("enter_acq", 32'(state_o), 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
        chk("acq_up_code", 32'(code_o), 35);

        // en=0 mid-ACQUIRE aborts to IDLE at the init code
        step(0, 0, 0, 0, 1, 0);
        chk("abort_state", 32'(state_o), 0);
        chk("abort_code", 32'(code_o), 32);
        step(1, 0, 0, 0, 0, 0);

        // alternating samples from 32: four reversals lock the loop
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, (i % 2) == 0);
        chk("lock_locked", 32'(locked_o), 1);
        chk("lock_state", 32'(state_o), 2);
        chk("lock_code", 32'(code_o), 31);

        // TRACK: 8 early samples give exactly two steps
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 1, 0);
        chk("track_code", 32'(code_o), 33);
        chk("track_locked", 32'(locked_o), 1);

        // manual override mid-TRACK, then release into ACQUIRE keeping the code
        step(1, 1, 10, 0, 1, 0);
        chk("man_code", 32'(code_o), 10);
        chk("man_locked", 32'(locked_o), 0);
        chk("man_state", 32'(state_o), 3);
        step(1, 0, 0, 0, 0, 0);
        chk("man_rel_state", 32'(state_o), 1);
        chk("man_rel_code", 32'(code_o), 10);

        // relock near the top of the range, ending at code 60
        step(1, 1, 61, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, (i % 2) == 0);
        chk("relock_state", 32'(state_o), 2);
        chk("relock_code", 32'(code_o), 60);

        // sustained early: climb to 63, blocked steps flag sat, 8th step drops lock
        sat_seen = 0;
        for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 1, 0);
        chk("sat_code", 32'(code_o), 63);
        chk("sat_pulses", 32'(sat_seen), 5);
        chk("loss_locked", 32'(locked_o), 0);
        chk("loss_state", 32'(state_o), 1);

        // freeze holds everything while pd toggles
        for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 1, (i % 2) == 1);
        chk("frz_code", 32'(code_o), 63);
        chk("frz_state", 32'(state_o), 1);
        step(1, 0, 0, 0, 1, 1);
        chk("unfrz_code", 32'(code_o), 62);

        step(0, 0, 0, 0, 0, 0);
        chk("final_state", 32'(state_o), 0);
        chk("final_code", 32'(code_o), 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
